// File: rtl/draw_pkg.sv
// Shared screen geometry, colour constants and scheduler state encoding
// for the VGA frame draw path.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame timer: counts 0..CYCLES_PER_FRAME-1 and flags the last
// count of every frame with a single-cycle tick.
module frame_tick_gen #(
    parameter int CYCLES_PER_FRAME = 3_333_333
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int               CNT_W = (CYCLES_PER_FRAME > 1) ? $clog2(CYCLES_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES_PER_FRAME - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/frame_draw_scheduler.sv
// Owns the VGA adapter write port: clears the screen at each frame start,
// then round-robin serves single-pixel plots from two requesters.
module frame_draw_scheduler
    import draw_pkg::*;
#(
    parameter int                   X_MAX            = SCREEN_W,
    parameter int                   Y_MAX            = SCREEN_H,
    parameter int                   CYCLES_PER_FRAME = 3_333_333,
    parameter logic [COLOUR_W-1:0]  CLEAR_COLOUR     = BLACK
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [COLOUR_W-1:0] c0,
    output logic                ack0,
    input  logic                req1,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] c1,
    output logic                ack1,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                frame_start,
    output logic                clear_done,
    output logic                overrun
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

    state_t              r_state;
    logic [X_W-1:0]      r_sx;
    logic [Y_W-1:0]      r_sy;
    logic                r_sweep_done;
    logic                r_new_frame;
    logic                r_prefer1;
    logic                r_plot;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_frame_start;
    logic                r_clear_done;
    logic                r_overrun;

    state_t              w_state_nxt;
    logic [X_W-1:0]      w_sx_nxt;
    logic [Y_W-1:0]      w_sy_nxt;
    logic                w_sweep_done_nxt;
    logic                w_new_frame_nxt;
    logic                w_prefer1_nxt;
    logic                w_plot_nxt;
    logic [X_W-1:0]      w_x_nxt;
    logic [Y_W-1:0]      w_y_nxt;
    logic [COLOUR_W-1:0] w_colour_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;
    logic                w_frame_start_nxt;
    logic                w_clear_done_nxt;
    logic                w_overrun_nxt;
    logic                w_tick;
    logic                w_elig0;
    logic                w_elig1;

    frame_tick_gen #(
        .CYCLES_PER_FRAME (CYCLES_PER_FRAME)
    ) u_frame_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    // A requester whose ack is showing this cycle has not yet dropped its req.
    assign w_elig0 = req0 && !r_ack0;
    assign w_elig1 = req1 && !r_ack1;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_sx_nxt          = r_sx;
        w_sy_nxt          = r_sy;
        w_sweep_done_nxt  = r_sweep_done;
        w_new_frame_nxt   = r_new_frame;
        w_prefer1_nxt     = r_prefer1;
        w_plot_nxt        = 1'b0;
        w_x_nxt           = r_x;
        w_y_nxt           = r_y;
        w_colour_nxt      = r_colour;
        w_ack0_nxt        = 1'b0;
        w_ack1_nxt        = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_clear_done_nxt  = 1'b0;
        w_overrun_nxt     = 1'b0;

        case (r_state)
            CLEAR: begin
                w_overrun_nxt = w_tick;
                if (r_sweep_done) begin
                    w_clear_done_nxt = 1'b1;
                    w_sweep_done_nxt = 1'b0;
                    w_sx_nxt         = '0;
                    w_sy_nxt         = '0;
                    w_state_nxt      = SERVE;
                end else begin
                    w_plot_nxt        = 1'b1;
                    w_x_nxt           = r_sx;
                    w_y_nxt           = r_sy;
                    w_colour_nxt      = CLEAR_COLOUR;
                    w_frame_start_nxt = r_new_frame;
                    w_new_frame_nxt   = 1'b0;
                    if (r_sx == X_LAST) begin
                        w_sx_nxt = '0;
                        if (r_sy == Y_LAST) begin
                            w_sweep_done_nxt = 1'b1;
                        end else begin
                            w_sy_nxt = r_sy + 1'b1;
                        end
                    end else begin
                        w_sx_nxt = r_sx + 1'b1;
                    end
                end
            end

            SERVE: begin
                if (w_tick) begin
                    w_state_nxt     = CLEAR;
                    w_sx_nxt        = '0;
                    w_sy_nxt        = '0;
                    w_new_frame_nxt = 1'b1;
                end else if (w_elig0 && (!w_elig1 || !r_prefer1)) begin
                    w_plot_nxt    = 1'b1;
                    w_x_nxt       = x0;
                    w_y_nxt       = y0;
                    w_colour_nxt  = c0;
                    w_ack0_nxt    = 1'b1;
                    w_prefer1_nxt = 1'b1;
                end else if (w_elig1) begin
                    w_plot_nxt    = 1'b1;
                    w_x_nxt       = x1;
                    w_y_nxt       = y1;
                    w_colour_nxt  = c1;
                    w_ack1_nxt    = 1'b1;
                    w_prefer1_nxt = 1'b0;
                end
            end

            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= CLEAR;
            r_sx          <= '0;
            r_sy          <= '0;
            r_sweep_done  <= 1'b0;
            r_new_frame   <= 1'b0;
            r_prefer1     <= 1'b0;
            r_plot        <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_colour      <= '0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_frame_start <= 1'b0;
            r_clear_done  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sx          <= w_sx_nxt;
            r_sy          <= w_sy_nxt;
            r_sweep_done  <= w_sweep_done_nxt;
            r_new_frame   <= w_new_frame_nxt;
            r_prefer1     <= w_prefer1_nxt;
            r_plot        <= w_plot_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_colour      <= w_colour_nxt;
            r_ack0        <= w_ack0_nxt;
            r_ack1        <= w_ack1_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_clear_done  <= w_clear_done_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    assign vga_plot    = r_plot;
    assign vga_x       = r_x;
    assign vga_y       = r_y;
    assign vga_colour  = r_colour;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign frame_start = r_frame_start;
    assign clear_done  = r_clear_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed plus randomized bench for frame_draw_scheduler on a 4x3 screen,
// checked every cycle against a pixel-index/frame-count reference model.
module tb_frame_draw_scheduler;
    import draw_pkg::*;

    localparam int XM   = 4;
    localparam int YM   = 3;
    localparam int NPIX = XM * YM;
    localparam int CPF  = 40;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                req0, req1;
    logic [X_W-1:0]      x0, x1;
    logic [Y_W-1:0]      y0, y1;
    logic [COLOUR_W-1:0] c0, c1;

    logic                ack0, ack1, vga_plot, frame_start, clear_done, overrun;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;

    logic                o_ack0, o_ack1, o_plot, o_frame_start, o_clear_done, o_overrun;
    logic [X_W-1:0]      o_x;
    logic [Y_W-1:0]      o_y;
    logic [COLOUR_W-1:0] o_colour;

    int checks   = 0;
    int failures = 0;

    // Reference model state: position in the sweep, frame timer, last grant.
    int                  m_cnt, m_idx, m_last;
    bit                  m_fs;
    logic                e_plot, e_ack0, e_ack1, e_fs, e_cd, e_ov;
    logic [X_W-1:0]      e_x;
    logic [Y_W-1:0]      e_y;
    logic [COLOUR_W-1:0] e_c;

    always #5 clk = ~clk;

    frame_draw_scheduler #(
        .X_MAX (XM), .Y_MAX (YM), .CYCLES_PER_FRAME (CPF), .CLEAR_COLOUR (BLACK)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .req0 (req0), .x0 (x0), .y0 (y0), .c0 (c0), .ack0 (ack0),
        .req1 (req1), .x1 (x1), .y1 (y1), .c1 (c1), .ack1 (ack1),
        .vga_x (vga_x), .vga_y (vga_y), .vga_colour (vga_colour), .vga_plot (vga_plot),
        .frame_start (frame_start), .clear_done (clear_done), .overrun (overrun)
    );

    frame_draw_scheduler #(
        .X_MAX (XM), .Y_MAX (YM), .CYCLES_PER_FRAME (8), .CLEAR_COLOUR (BLACK)
    ) dut_ovr (
        .clk (clk), .reset_n (reset_n),
        .req0 (req0), .x0 (x0), .y0 (y0), .c0 (c0), .ack0 (o_ack0),
        .req1 (req1), .x1 (x1), .y1 (y1), .c1 (c1), .ack1 (o_ack1),
        .vga_x (o_x), .vga_y (o_y), .vga_colour (o_colour), .vga_plot (o_plot),
        .frame_start (o_frame_start), .clear_done (o_clear_done), .overrun (o_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tk, el0, el1;
        int g;
        if (!reset_n) begin
            {e_plot, e_ack0, e_ack1, e_fs, e_cd, e_ov} = '0;
            e_x = '0; e_y = '0; e_c = '0;
            m_cnt = 0; m_idx = 0; m_last = 1; m_fs = 0;
        end else begin
            tk    = (m_cnt == CPF - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            el0   = req0 && !e_ack0;
            el1   = req1 && !e_ack1;
            {e_plot, e_ack0, e_ack1, e_fs, e_cd, e_ov} = '0;
            g = -1;
            if (m_idx >= 0) begin
                e_ov = tk;
                if (m_idx == NPIX) begin
                    e_cd  = 1'b1;
                    m_idx = -1;
                end else begin
                    e_plot = 1'b1;
                    e_x    = X_W'(m_idx % XM);
                    e_y    = Y_W'(m_idx / XM);
                    e_c    = BLACK;
                    e_fs   = m_fs;
                    m_fs   = 0;
                    m_idx++;
                end
            end else if (tk) begin
                m_idx = 0;
                m_fs  = 1;
            end else if (el0 && el1) begin
                g = 1 - m_last;
            end else if (el0) begin
                g = 0;
            end else if (el1) begin
                g = 1;
            end
            if (g == 0) begin
                e_plot = 1'b1; e_x = x0; e_y = y0; e_c = c0; e_ack0 = 1'b1; m_last = 0;
            end else if (g == 1) begin
                e_plot = 1'b1; e_x = x1; e_y = y1; e_c = c1; e_ack1 = 1'b1; m_last = 1;
            end
        end
    endtask

    // One clock: update the model at the edge, compare all outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("plot",        32'(vga_plot),    32'(e_plot));
        check("x",           32'(vga_x),       32'(e_x));
        check("y",           32'(vga_y),       32'(e_y));
        check("colour",      32'(vga_colour),  32'(e_c));
        check("ack0",        32'(ack0),        32'(e_ack0));
        check("ack1",        32'(ack1),        32'(e_ack1));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("clear_done",  32'(clear_done),  32'(e_cd));
        check("overrun",     32'(overrun),     32'(e_ov));
    endtask

    task automatic drive_random();
        if (req0 && e_ack0) begin
            req0 = 1'b0;
        end else if (!req0 && $urandom_range(0, 1) == 1) begin
            req0 = 1'b1; x0 = X_W'($urandom); y0 = Y_W'($urandom); c0 = COLOUR_W'($urandom);
        end
        if (req1 && e_ack1) begin
            req1 = 1'b0;
        end else if (!req1 && $urandom_range(0, 1) == 1) begin
            req1 = 1'b1; x1 = X_W'($urandom); y1 = Y_W'($urandom); c1 = COLOUR_W'($urandom);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; x0 = '0; y0 = '0; c0 = '0;
        req1 = 1'b0; x1 = '0; y1 = '0; c1 = '0;

        repeat (2) step();
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_x",    32'(vga_x),    0);

        // Initial sweep; req0 is already pending and must be ignored.
        reset_n = 1'b1;
        req0 = 1'b1; x0 = 8'd5; y0 = 7'd6; c0 = RED;
        for (int k = 0; k < NPIX; k++) begin
            step();
            check("clr_plot", 32'(vga_plot), 1);
            check("clr_x",    32'(vga_x),    k % XM);
            check("clr_y",    32'(vga_y),    k / XM);
            check("clr_ack0", 32'(ack0),     0);
            check("ovr_x",    32'(o_x),      k % XM);
            check("ovr_y",    32'(o_y),      k / XM);
            check("ovr_plot", 32'(o_plot),   1);
            check("ovr_pulse", 32'(o_overrun), (k == 7) ? 1 : 0);
        end
        step();
        check("cd_pulse",   32'(clear_done),   1);
        check("cd_plot",    32'(vga_plot),     0);
        check("ovr_cd",     32'(o_clear_done), 1);
        check("ovr_after",  32'(o_overrun),    0);

        // req0 alone: grant, gap, grant.
        step();
        check("r0_ack",  32'(ack0),       1);
        check("r0_x",    32'(vga_x),      5);
        check("r0_y",    32'(vga_y),      6);
        check("r0_col",  32'(vga_colour), 4);
        step();
        check("r0_gap",  32'(ack0),       0);
        check("r0_hold", 32'(vga_x),      5);
        step();
        check("r0_next", 32'(ack0),       1);
        repeat (5) step();

        // Both held: alternation, never two acks at once.
        req1 = 1'b1; x1 = 8'd7; y1 = 7'd2; c1 = GREEN;
        step();
        check("rr_first1", 32'(ack1), 1);
        check("rr_x1",     32'(vga_x), 7);
        step();
        check("rr_then0",  32'(ack0), 1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_one_ack", 32'(ack0 ^ ack1), 1);
            check("rr_alt0",    32'(ack0), (k % 2 == 0) ? 0 : 1);
        end

        // Idle, then req1 raised in the tick cycle: tick wins, req1 waits.
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) step();
        req1 = 1'b1; x1 = 8'd9; y1 = 7'd4; c1 = GREEN;
        step();
        check("tick_no_ack1", 32'(ack1),     0);
        check("tick_no_plot", 32'(vga_plot), 0);
        step();
        check("fs_pulse", 32'(frame_start), 1);
        check("fs_plot",  32'(vga_plot),    1);
        check("fs_x",     32'(vga_x),       0);
        check("fs_y",     32'(vga_y),       0);
        repeat (NPIX - 1) step();
        step();
        check("cd2_pulse", 32'(clear_done), 1);
        step();
        check("late_ack1", 32'(ack1),  1);
        check("late_x1",   32'(vga_x), 9);
        req1 = 1'b0;

        // Random traffic across a frame boundary.
        repeat (57) begin
            step();
            drive_random();
        end

        // Reset pulse while an ack0 is due at the next edge.
        req0 = 1'b0; req1 = 1'b0;
        step();
        reset_n = 1'b0;
        req0 = 1'b1; x0 = 8'd3; y0 = 7'd1; c0 = RED;
        step();
        check("mid_rst_ack0", 32'(ack0),     0);
        check("mid_rst_plot", 32'(vga_plot), 0);
        check("mid_rst_x",    32'(vga_x),    0);
        reset_n = 1'b1;
        step();
        check("restart_x",  32'(vga_x),       0);
        check("restart_y",  32'(vga_y),       0);
        check("restart_fs", 32'(frame_start), 0);
        repeat (NPIX - 1) step();
        step();
        check("cd3_pulse", 32'(clear_done), 1);
        step();
        check("post_rst_ack0", 32'(ack0),  1);
        check("post_rst_x",    32'(vga_x), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
